multiword_add_seq: RTL
======================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter W, default 64, width in bits of one adder word slice.
REQ-002 SHALL have parameter WORDS, default 4, number of word slices per operand (operand width W*WORDS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand transfer offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports A, B  input  W*WORDS  operands.
REQ-008 SHALL have port Cin  input  1  carry into word 0.
REQ-009 SHALL have port out_valid  output  1  result held and valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port S  output  W*WORDS  registered sum.
REQ-012 SHALL have port Cout  output  1  registered carry out of the top word.
REQ-013 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL assert in_ready only in IDLE. in_valid in any other state is ignored.
REQ-016 SHALL leave IDLE for RUN on in_valid&&in_ready. It captures A, B, Cin, clears the word index, and loads the carry register with Cin.
REQ-017 SHALL perform one W-bit add per RUN cycle on word idx (bits idx*W+W-1 : idx*W) using the carry register as carry-in.
REQ-018 SHALL write the slice result into S[idx] and the slice carry-out into the carry register on that same edge, then increment idx.
REQ-019 SHALL go RUN->DONE on the edge that processes word WORDS-1, loading Cout from that slice carry-out.
REQ-020 SHALL assert out_valid only in DONE, exactly WORDS cycles after the accepting edge.
REQ-021 SHALL hold S and Cout stable in DONE until out_valid&&out_ready, then go to IDLE. There is no back-to-back accept in the handshake cycle.
REQ-022 SHALL hold the upper S words at their previous values during RUN; S is defined only while out_valid=1.
REQ-023 SHALL not use idx values >= WORDS; idx width = clog2(WORDS), minimum 1.
REQ-024 SHALL produce the sum modulo 2^(W*WORDS), with the carry propagated across all word boundaries.

Reset
REQ-025 SHALL on rst_n low force state IDLE, idx 0, carry 0, S 0, Cout 0, out_valid 0, busy 0. in_ready reads 1 once rst_n is high.
REQ-026 SHALL abort any in-flight RUN or DONE on reset. The discarded result is never presented.

Configuration
REQ-027 SHALL support macro MULTIWORD_ADD_SEQ_SUB_EN.
- When defined: adds input port sub (1 bit), captured at accept. If sub=1, every B word is inverted and the carry register is loaded with 1 (A-B; Cin ignored).
- When undefined: port sub is absent and the block adds only.

Structure
REQ-028 SHALL place the state enum, the default W/WORDS constants and the idx width function in shared package addseq_pkg.
REQ-029 SHALL instantiate one combinational sub-module, word_csel_adder (W-bit carry-select slice: a, b, cin -> s, cout), exactly once. It is time-shared across words.

Verification
REQ-030 SHALL cover: A=2^256-1, B=1, Cin=0 -> S=0, Cout=1, out_valid exactly 4 cycles after accept.
REQ-031 SHALL cover: A=0x0..0_FFFFFFFFFFFFFFFF, B=1 -> S=2^64 (word1=1, others 0), Cout=0.
REQ-032 SHALL cover: out_ready=0 for 10 cycles in DONE -> out_valid, S and Cout stable, in_ready=0, new in_valid ignored.
REQ-033 SHALL cover: rst_n pulsed low after 2 RUN cycles -> out_valid never rises for that operation, in_ready=1 first cycle after release, next operation correct.
REQ-034 SHALL cover: A=3, B=5, Cin=1, then out_ready=1 in the same cycle as out_valid -> S=9, IDLE next cycle, second operation accepted after that.
REQ-035 SHALL cover (SUB_EN only): A=5, B=7, sub=1 -> S=2^256-2, Cout=0. A=7, B=5, sub=1 -> S=2, Cout=1.

Source files
------------

// File: rtl/addseq_pkg.sv
// addseq_pkg: shared FSM states, default sizes and index-width helper for multiword_add_seq.
package addseq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int W_DEF = 64;
  localparam int WORDS_DEF = 4;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/word_csel_adder.sv
// word_csel_adder: W-bit carry-select adder slice, both carry cases precomputed and selected by cin.
module word_csel_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] r0, r1;
  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + (W+1)'(1);
  assign {cout, s} = cin ? r1 : r0;
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: word-serial W*WORDS-bit adder sharing one carry-select slice over WORDS cycles.
// Optional MULTIWORD_ADD_SEQ_SUB_EN adds port sub for A-B.
module multiword_add_seq
  import addseq_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] A,
  input  logic [W*WORDS-1:0] B,
  input  logic               Cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] S,
  output logic               Cout,
  output logic               busy
);
  localparam int IW = idx_w(WORDS);
  localparam int N = W * WORDS;
  state_t state, next;
  logic [IW-1:0] idx;
  logic carry, cout_r, slice_c, last, sb;
  logic [N-1:0] a_r, b_r, s_r;
  logic [W-1:0] slice_s;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  assign sb = sub;
`else
  assign sb = 1'b0;
`endif
  assign last = idx == IW'(WORDS - 1);
  word_csel_adder #(.W(W)) u_slice (
    .a(a_r[idx*W +: W]),
    .b(b_r[idx*W +: W]),
    .cin(carry),
    .s(slice_s),
    .cout(slice_c)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = in_valid ? RUN : IDLE;
      RUN: next = last ? DONE : RUN;
      DONE: next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      cout_r <= 1'b0;
      s_r <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      state <= next;
      if (state == IDLE && in_valid) begin
        a_r <= A;
        b_r <= sb ? ~B : B;
        carry <= sb | Cin;
        idx <= '0;
      end else if (state == RUN) begin
        s_r[idx*W +: W] <= slice_s;
        carry <= slice_c;
        idx <= last ? '0 : idx + IW'(1);
        if (last) cout_r <= slice_c;
      end
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign S = s_r;
  assign Cout = cout_r;
endmodule
